// File: rtl/conv2d_stream_if.sv
// Control and weight/feature/result valid-ready streams of the conv2d_stream engine.
interface conv2d_stream_if #(
  parameter int DATA_W = 16
);
  logic                     start_i;
  logic                     busy_o;
  logic                     done_o;
  logic signed [DATA_W-1:0] w_data_i;
  logic                     w_valid_i;
  logic                     w_ready_o;
  logic signed [DATA_W-1:0] f_data_i;
  logic                     f_valid_i;
  logic                     f_ready_o;
  logic signed [DATA_W-1:0] o_data_o;
  logic                     o_valid_o;
  logic                     o_ready_i;
  logic                     o_last_o;

  modport slave (
    input  start_i, w_data_i, w_valid_i, f_data_i, f_valid_i, o_ready_i,
    output busy_o, done_o, w_ready_o, f_ready_o, o_data_o, o_valid_o, o_last_o
  );

  modport master (
    output start_i, w_data_i, w_valid_i, f_data_i, f_valid_i, o_ready_i,
    input  busy_o, done_o, w_ready_o, f_ready_o, o_data_o, o_valid_o, o_last_o
  );
endinterface

// File: rtl/conv2d_stream.sv
// Streaming KxK 2-D convolution (valid padding): loads a kernel, then runs a raster
// feature stream through K-1 line buffers and emits shifted, saturated results.
module conv2d_stream #(
  parameter int DATA_W = 16,
  parameter int K      = 3,
  parameter int H      = 32,
  parameter int W      = 32,
  parameter int SHIFT  = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  conv2d_stream_if.slave bus
);
  localparam int ACC_W = 2 * DATA_W + $clog2(K * K);
  localparam int PW    = 2 * DATA_W;
  localparam int NW    = K * K;
  localparam int WCW   = $clog2(NW);
  localparam int RW    = $clog2(H);
  localparam int CW    = $clog2(W);

  localparam logic signed [ACC_W-1:0]  ACC_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WLOAD, FEAT, DONE} state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] wt_q  [NW];
  logic signed [DATA_W-1:0] lb_q  [K-1][W];
  logic signed [DATA_W-1:0] win_q [K][K-1];
  logic signed [DATA_W-1:0] colv  [K];
  logic [WCW-1:0]           wcnt_q;
  logic [RW-1:0]            row_q;
  logic [CW-1:0]            col_q;
  logic                     o_valid_q;
  logic                     o_last_q;
  logic signed [DATA_W-1:0] o_data_q;

  logic                     w_ready, f_ready, w_hs, f_hs, o_hs, produce, last_pix;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc, shifted;
  logic signed [DATA_W-1:0] res;

  // Once the final pixel's result is pending, the frame is closed to further pixels.
  assign w_ready  = (state_q == WLOAD);
  assign f_ready  = (state_q == FEAT) && !o_last_q && (!o_valid_q || bus.o_ready_i);
  assign w_hs     = bus.w_valid_i && w_ready;
  assign f_hs     = bus.f_valid_i && f_ready;
  assign o_hs     = o_valid_q && bus.o_ready_i;
  assign produce  = f_hs && (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));
  assign last_pix = (row_q == RW'(H-1)) && (col_q == CW'(W-1));

  // Newest window column: line buffer j holds row (row-1-j) at the current column.
  always_comb begin
    colv[K-1] = bus.f_data_i;
    for (int r = 0; r < K-1; r++) colv[r] = lb_q[K-2-r][col_q];
  end

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) begin
        prod = PW'(wt_q[r*K+c]) * PW'(win_q[r][c]);
        acc  = acc + ACC_W'(prod);
      end
      prod = PW'(wt_q[r*K+K-1]) * PW'(colv[r]);
      acc  = acc + ACC_W'(prod);
    end
    shifted = acc >>> SHIFT;
    if (shifted > ACC_MAX)      res = OUT_MAX;
    else if (shifted < ACC_MIN) res = OUT_MIN;
    else                        res = shifted[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = WLOAD;
      WLOAD:   if (w_hs && wcnt_q == WCW'(NW-1)) state_d = FEAT;
      FEAT:    if (o_hs && o_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
      for (int i = 0; i < NW; i++) wt_q[i] <= '0;
      for (int j = 0; j < K-1; j++)
        for (int c = 0; c < W; c++) lb_q[j][c] <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K-1; c++) win_q[r][c] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start_i) begin
        wcnt_q <= '0;
        row_q  <= '0;
        col_q  <= '0;
      end
      if (w_hs) begin
        wt_q[wcnt_q] <= bus.w_data_i;
        wcnt_q       <= wcnt_q + WCW'(1);
      end
      if (f_hs) begin
        lb_q[0][col_q] <= bus.f_data_i;
        for (int j = 1; j < K-1; j++) lb_q[j][col_q] <= lb_q[j-1][col_q];
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K-2; c++) win_q[r][c] <= win_q[r][c+1];
          win_q[r][K-2] <= colv[r];
        end
        if (col_q == CW'(W-1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      // A new result may replace one being handed off in the same cycle.
      if (produce) begin
        o_valid_q <= 1'b1;
        o_data_q  <= res;
        o_last_q  <= last_pix;
      end else if (o_hs) begin
        o_valid_q <= 1'b0;
        o_last_q  <= 1'b0;
      end
    end
  end

  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = (state_q == DONE);
  assign bus.w_ready_o = w_ready;
  assign bus.f_ready_o = f_ready;
  assign bus.o_data_o  = o_data_q;
  assign bus.o_valid_o = o_valid_q;
  assign bus.o_last_o  = o_last_q;
endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream: a 6x6/K=3 16-bit instance and a 3x3/K=3 8-bit SHIFT=4 instance.
module tb_conv2d_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv2d_stream_if #(.DATA_W(16)) a_if ();
  conv2d_stream_if #(.DATA_W(8))  b_if ();

  conv2d_stream #(.DATA_W(16), .K(3), .H(6), .W(6), .SHIFT(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(a_if));
  conv2d_stream #(.DATA_W(8), .K(3), .H(3), .W(3), .SHIFT(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(b_if));

  int vec_cnt = 0;
  int err_cnt = 0;

  logic signed [15:0] wts [9];
  logic signed [15:0] img [36];
  logic signed [7:0]  bw  [9];
  logic signed [7:0]  bf  [9];
  logic signed [15:0] got_q [$];
  bit                 got_last [$];
  int gap_pct = 0, stall_pct = 0;
  bit start_poke = 0;
  int hs_last_cyc, done_cyc, done_cnt, stable_err;
  bit drv_timeout, col_timeout;

  // Direct convolution of the current wts/img at output (y,x), saturated to 16 bits.
  function automatic logic signed [15:0] model_out(int y, int x);
    longint acc = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        acc += longint'(wts[r*3+c]) * longint'(img[(y+r)*6 + x + c]);
    if (acc > 32767)  return 16'sh7fff;
    if (acc < -32768) return 16'sh8000;
    return 16'(acc);
  endfunction

  task automatic drive_job();
    int i = 0;
    bit hs = 0;
    drv_timeout = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(posedge clk); #1;
      if (hs) i++;
      if (i == 9) break;
      a_if.w_valid_i = ($urandom_range(99) >= gap_pct);
      a_if.w_data_i  = wts[i];
      #1 hs = a_if.w_valid_i && a_if.w_ready_o;
    end
    a_if.w_valid_i = 0;
    if (i < 9) drv_timeout = 1;
    i  = 0;
    hs = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      if (hs) i++;
      if (i == 36) break;
      a_if.f_valid_i = ($urandom_range(99) >= gap_pct);
      a_if.f_data_i  = img[i];
      #1 hs = a_if.f_valid_i && a_if.f_ready_o;
    end
    a_if.f_valid_i = 0;
    if (i < 36) drv_timeout = 1;
  endtask

  task automatic collect_job();
    int cyc = 0, post = 0;
    bit prev_stall = 0;
    bit prev_l = 0;
    logic signed [15:0] prev_d = '0;
    got_q.delete();
    got_last.delete();
    done_cnt = 0; stable_err = 0; hs_last_cyc = -10; done_cyc = -1; col_timeout = 0;
    while (1) begin
      @(posedge clk); #1;
      a_if.o_ready_i = ($urandom_range(99) >= stall_pct);
      a_if.start_i   = start_poke && (cyc == 3 || cyc == 25);
      @(negedge clk);
      cyc++;
      if (prev_stall && (a_if.o_valid_o !== 1'b1 || a_if.o_data_o !== prev_d || a_if.o_last_o !== prev_l))
        stable_err++;
      prev_stall = a_if.o_valid_o && !a_if.o_ready_i;
      prev_d     = a_if.o_data_o;
      prev_l     = a_if.o_last_o;
      if (a_if.o_valid_o && a_if.o_ready_i) begin
        got_q.push_back(a_if.o_data_o);
        got_last.push_back(a_if.o_last_o);
        hs_last_cyc = cyc;
      end
      if (a_if.done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cnt > 0) post++;
      if (post > 3) break;
      if (cyc > 3000) begin
        col_timeout = 1;
        break;
      end
    end
    a_if.o_ready_i = 0;
    a_if.start_i   = 0;
  endtask

  task automatic run_job();
    @(posedge clk); #1 a_if.start_i = 1;
    @(posedge clk); #1 a_if.start_i = 0;
    fork
      drive_job();
      collect_job();
    join
  endtask

  task automatic b_job(output logic signed [7:0] res, output bit seen);
    int i = 0;
    bit hs = 0;
    seen = 0;
    res  = '0;
    b_if.o_ready_i = 1;
    @(posedge clk); #1 b_if.start_i = 1;
    @(posedge clk); #1 b_if.start_i = 0;
    for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
      if (hs) i++;
      b_if.w_valid_i = (i < 9);
      b_if.w_data_i  = bw[(i < 9) ? i : 0];
      b_if.f_valid_i = (i >= 9 && i < 18);
      b_if.f_data_i  = bf[(i >= 9 && i < 18) ? i - 9 : 0];
      #1 hs = (b_if.w_valid_i && b_if.w_ready_o) || (b_if.f_valid_i && b_if.f_ready_o);
      @(negedge clk);
      if (b_if.o_valid_o) begin
        seen = 1;
        res  = b_if.o_data_o;
      end
      @(posedge clk); #1;
    end
    b_if.w_valid_i = 0;
    b_if.f_valid_i = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vec_cnt++; if (a_if.busy_o !== 1'b0)    begin err_cnt++; $display("[TB] FAIL reset_busy: got %b want 0", a_if.busy_o); end
    vec_cnt++; if (a_if.done_o !== 1'b0)    begin err_cnt++; $display("[TB] FAIL reset_done: got %b want 0", a_if.done_o); end
    vec_cnt++; if (a_if.w_ready_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_w_ready: got %b want 0", a_if.w_ready_o); end
    vec_cnt++; if (a_if.f_ready_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_f_ready: got %b want 0", a_if.f_ready_o); end
    vec_cnt++; if (a_if.o_valid_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_o_valid: got %b want 0", a_if.o_valid_o); end
    vec_cnt++; if (a_if.o_last_o !== 1'b0)  begin err_cnt++; $display("[TB] FAIL reset_o_last: got %b want 0", a_if.o_last_o); end
    vec_cnt++; if (a_if.o_data_o !== 16'd0) begin err_cnt++; $display("[TB] FAIL reset_o_data: got %0d want 0", a_if.o_data_o); end
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_identity();
    int exp_v;
    for (int i = 0; i < 9; i++) wts[i] = (i == 4) ? 16'sd1 : 16'sd0;
    for (int i = 0; i < 36; i++) img[i] = 16'(i);
    gap_pct = 0; stall_pct = 0;
    run_job();
    vec_cnt++; if (drv_timeout || col_timeout) begin err_cnt++; $display("[TB] FAIL ident_timeout: got drv=%b col=%b want 0 0", drv_timeout, col_timeout); end
    vec_cnt++; if (got_q.size() != 16) begin err_cnt++; $display("[TB] FAIL ident_count: got %0d want 16", got_q.size()); end
    for (int k = 0; k < 16; k++) begin
      exp_v = (k / 4 + 1) * 6 + (k % 4 + 1);
      vec_cnt++;
      if (k >= got_q.size()) begin err_cnt++; $display("[TB] FAIL ident_out[%0d]: got none want %0d", k, exp_v); end
      else if (got_q[k] !== 16'(exp_v) || got_last[k] !== (k == 15)) begin
        err_cnt++;
        $display("[TB] FAIL ident_out[%0d]: got %0d last=%b want %0d last=%b", k, got_q[k], got_last[k], exp_v, k == 15);
      end
    end
    vec_cnt++; if (a_if.busy_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL ident_idle_after: got busy=%b want 0", a_if.busy_o); end
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < 9; i++) wts[i] = 16'sd1;
    for (int i = 0; i < 36; i++) img[i] = 16'sd100;
    gap_pct = 0; stall_pct = 0;
    run_job();
    vec_cnt++; if (got_q.size() != 16) begin err_cnt++; $display("[TB] FAIL ones_count: got %0d want 16", got_q.size()); end
    for (int k = 0; k < got_q.size(); k++) begin
      vec_cnt++;
      if (got_q[k] !== 16'sd900) begin err_cnt++; $display("[TB] FAIL ones_out[%0d]: got %0d want 900", k, got_q[k]); end
    end
    vec_cnt++; if (done_cnt != 1) begin err_cnt++; $display("[TB] FAIL ones_done_pulses: got %0d want 1", done_cnt); end
    vec_cnt++; if (done_cyc != hs_last_cyc + 1) begin err_cnt++; $display("[TB] FAIL ones_done_latency: got cycle %0d want %0d", done_cyc, hs_last_cyc + 1); end
  endtask

  task automatic test_saturation();
    logic signed [7:0] r;
    bit seen;
    for (int i = 0; i < 9; i++) begin bw[i] = 8'sd127; bf[i] = 8'sd127; end
    b_job(r, seen);
    vec_cnt++; if (!seen || r !== 8'sd127) begin err_cnt++; $display("[TB] FAIL sat_high: got %0d seen=%b want 127", r, seen); end
    for (int i = 0; i < 9; i++) begin bw[i] = 8'sd127; bf[i] = -8'sd128; end
    b_job(r, seen);
    vec_cnt++; if (!seen || r !== -8'sd128) begin err_cnt++; $display("[TB] FAIL sat_low: got %0d seen=%b want -128", r, seen); end
    for (int i = 0; i < 9; i++) begin bw[i] = (i == 4) ? -8'sd17 : 8'sd0; bf[i] = 8'sd1; end
    b_job(r, seen);
    vec_cnt++; if (!seen || r !== -8'sd2) begin err_cnt++; $display("[TB] FAIL shift_floor_neg: got %0d seen=%b want -2", r, seen); end
    for (int i = 0; i < 9; i++) begin bw[i] = 8'sd1; bf[i] = 8'sd16; end
    b_job(r, seen);
    vec_cnt++; if (!seen || r !== 8'sd9) begin err_cnt++; $display("[TB] FAIL shift_pos: got %0d seen=%b want 9", r, seen); end
  endtask

  task automatic test_random_gaps();
    logic signed [15:0] exp_v;
    for (int i = 0; i < 9; i++)  wts[i] = 16'(int'($urandom_range(600)) - 300);
    for (int i = 0; i < 36; i++) img[i] = 16'(int'($urandom_range(1000)) - 500);
    gap_pct = 30; stall_pct = 40;
    run_job();
    vec_cnt++; if (drv_timeout || col_timeout) begin err_cnt++; $display("[TB] FAIL rand_timeout: got drv=%b col=%b want 0 0", drv_timeout, col_timeout); end
    vec_cnt++; if (got_q.size() != 16) begin err_cnt++; $display("[TB] FAIL rand_count: got %0d want 16", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 16; k++) begin
      exp_v = model_out(k / 4, k % 4);
      vec_cnt++;
      if (got_q[k] !== exp_v || got_last[k] !== (k == 15)) begin
        err_cnt++;
        $display("[TB] FAIL rand_out[%0d]: got %0d last=%b want %0d last=%b", k, got_q[k], got_last[k], exp_v, k == 15);
      end
    end
    vec_cnt++; if (stable_err != 0) begin err_cnt++; $display("[TB] FAIL rand_stall_stable: got %0d changes want 0", stable_err); end
    gap_pct = 0; stall_pct = 0;
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] exp_v;
    a_if.o_ready_i = 0;
    @(posedge clk); #1 a_if.start_i = 1;
    @(posedge clk); #1 a_if.start_i = 0;
    for (int i = 0; i < 9; i++) begin
      a_if.w_valid_i = 1; a_if.w_data_i = 16'sd2;
      @(posedge clk); #1;
    end
    a_if.w_valid_i = 0;
    for (int i = 0; i < 20; i++) begin
      a_if.f_valid_i = 1; a_if.f_data_i = 16'(i + 1);
      @(posedge clk); #1;
    end
    vec_cnt++; if (a_if.busy_o !== 1'b1 || a_if.o_valid_o !== 1'b1) begin err_cnt++; $display("[TB] FAIL midrst_pre: got busy=%b o_valid=%b want 1 1", a_if.busy_o, a_if.o_valid_o); end
    rst = 1;
    #1;
    vec_cnt++; if (a_if.busy_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL midrst_busy: got %b want 0", a_if.busy_o); end
    vec_cnt++; if (a_if.o_valid_o !== 1'b0 || a_if.o_data_o !== 16'd0 || a_if.o_last_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL midrst_out: got v=%b d=%0d l=%b want 0 0 0", a_if.o_valid_o, a_if.o_data_o, a_if.o_last_o); end
    vec_cnt++; if (a_if.f_ready_o !== 1'b0 || a_if.w_ready_o !== 1'b0 || a_if.done_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL midrst_ctl: got f=%b w=%b d=%b want 0 0 0", a_if.f_ready_o, a_if.w_ready_o, a_if.done_o); end
    a_if.f_valid_i = 0;
    @(posedge clk); #1;
    vec_cnt++; if (a_if.busy_o !== 1'b0 || a_if.done_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL midrst_next: got busy=%b done=%b want 0 0", a_if.busy_o, a_if.done_o); end
    rst = 0;
    for (int i = 0; i < 9; i++)  wts[i] = 16'(int'($urandom_range(400)) - 200);
    for (int i = 0; i < 36; i++) img[i] = 16'(int'($urandom_range(800)) - 400);
    gap_pct = 20; stall_pct = 25;
    run_job();
    vec_cnt++; if (got_q.size() != 16) begin err_cnt++; $display("[TB] FAIL midrst_count: got %0d want 16", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 16; k++) begin
      exp_v = model_out(k / 4, k % 4);
      vec_cnt++;
      if (got_q[k] !== exp_v) begin err_cnt++; $display("[TB] FAIL midrst_out[%0d]: got %0d want %0d", k, got_q[k], exp_v); end
    end
    gap_pct = 0; stall_pct = 0;
  endtask

  task automatic test_start_ignored();
    logic signed [15:0] exp_v;
    for (int i = 0; i < 9; i++)  wts[i] = 16'(int'($urandom_range(200)) - 100);
    for (int i = 0; i < 36; i++) img[i] = 16'(int'($urandom_range(200)) - 100);
    start_poke = 1;
    run_job();
    start_poke = 0;
    vec_cnt++; if (got_q.size() != 16) begin err_cnt++; $display("[TB] FAIL poke_count: got %0d want 16", got_q.size()); end
    vec_cnt++; if (done_cnt != 1) begin err_cnt++; $display("[TB] FAIL poke_done_pulses: got %0d want 1", done_cnt); end
    for (int k = 0; k < got_q.size() && k < 16; k++) begin
      exp_v = model_out(k / 4, k % 4);
      vec_cnt++;
      if (got_q[k] !== exp_v) begin err_cnt++; $display("[TB] FAIL poke_out[%0d]: got %0d want %0d", k, got_q[k], exp_v); end
    end
  endtask

  initial begin
    a_if.start_i = 0; a_if.w_data_i = '0; a_if.w_valid_i = 0;
    a_if.f_data_i = '0; a_if.f_valid_i = 0; a_if.o_ready_i = 0;
    b_if.start_i = 0; b_if.w_data_i = '0; b_if.w_valid_i = 0;
    b_if.f_data_i = '0; b_if.f_valid_i = 0; b_if.o_ready_i = 0;
    test_reset();
    test_identity();
    test_all_ones();
    test_saturation();
    test_random_gaps();
    test_reset_mid();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
